// File: rtl/mux2_stream_arb.sv
// mux2_stream_arb: registered two-input valid/ready arbiter feeding a single-entry output register.
// Define MUX2_STREAM_ARB_RR_EN for round-robin on contention; otherwise in0 has fixed priority.
module mux2_stream_arb #(
    parameter int DW    = 8,
    parameter int CNT_W = 8
) (
    input  logic             i_clk,
    input  logic             i_rstn,
    input  logic [DW-1:0]    i_in0_data,
    input  logic             i_in0_valid,
    output logic             o_in0_ready,
    input  logic [DW-1:0]    i_in1_data,
    input  logic             i_in1_valid,
    output logic             o_in1_ready,
    output logic [DW-1:0]    o_out_data,
    output logic             o_out_valid,
    input  logic             i_out_ready,
    output logic             o_sel,
    output logic [CNT_W-1:0] o_cnt0,
    output logic [CNT_W-1:0] o_cnt1
);
    logic load, any_vld, both_vld, grant, last_sel, xfer0, xfer1;

    assign load     = !o_out_valid || i_out_ready;
    assign any_vld  = i_in0_valid || i_in1_valid;
    assign both_vld = i_in0_valid && i_in1_valid;

`ifdef MUX2_STREAM_ARB_RR_EN
    assign grant = both_vld ? !last_sel : i_in1_valid;
`else
    logic unused_last_sel;
    assign unused_last_sel = last_sel;
    assign grant = both_vld ? 1'b0 : i_in1_valid;
`endif

    // Ready is gated by reset so both readies read low while held in reset.
    assign o_in0_ready = i_rstn && load && any_vld && !grant;
    assign o_in1_ready = i_rstn && load && any_vld && grant;
    assign xfer0 = i_in0_valid && o_in0_ready;
    assign xfer1 = i_in1_valid && o_in1_ready;

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            o_out_data  <= '0;
            o_out_valid <= 1'b0;
            o_sel       <= 1'b0;
            o_cnt0      <= '0;
            o_cnt1      <= '0;
            last_sel    <= 1'b1;
        end else begin
            if (load)
                o_out_valid <= any_vld;
            if (xfer0) begin
                o_out_data <= i_in0_data;
                o_sel      <= 1'b0;
                last_sel   <= 1'b0;
                o_cnt0     <= o_cnt0 + 1'b1;
            end
            if (xfer1) begin
                o_out_data <= i_in1_data;
                o_sel      <= 1'b1;
                last_sel   <= 1'b1;
                o_cnt1     <= o_cnt1 + 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_mux2_stream_arb.sv
// tb_mux2_stream_arb: directed self-checking bench for mux2_stream_arb.
module tb_mux2_stream_arb;
    logic       clk = 1'b0;
    logic       rstn = 1'b0;
    logic [7:0] d0 = '0, d1 = '0, out_data;
    logic       v0 = 1'b0, v1 = 1'b0, r0, r1, out_valid, out_ready = 1'b0, sel;
    logic [7:0] cnt0, cnt1;
    int         pass_cnt = 0, total = 0;

    mux2_stream_arb #(.DW(8), .CNT_W(8)) dut (
        .i_clk(clk), .i_rstn(rstn),
        .i_in0_data(d0), .i_in0_valid(v0), .o_in0_ready(r0),
        .i_in1_data(d1), .i_in1_valid(v1), .o_in1_ready(r1),
        .o_out_data(out_data), .o_out_valid(out_valid), .i_out_ready(out_ready),
        .o_sel(sel), .o_cnt0(cnt0), .o_cnt1(cnt1)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        v0 = 1'b0; v1 = 1'b0; out_ready = 1'b0;
        rstn = 1'b0;
        step();
        rstn = 1'b1;
    endtask

    task automatic test_reset();
        rstn = 1'b0; v0 = 1'b1; v1 = 1'b1; d0 = 8'h3C; d1 = 8'h4D; out_ready = 1'b1;
        repeat (3) step();
        total++; if (out_valid !== 1'b0) $display("FAIL reset_valid got %b want 0", out_valid); else pass_cnt++;
        total++; if (out_data !== 8'h00) $display("FAIL reset_data got %h want 00", out_data); else pass_cnt++;
        total++; if (sel !== 1'b0) $display("FAIL reset_sel got %b want 0", sel); else pass_cnt++;
        total++; if ({cnt0, cnt1} !== 16'h0) $display("FAIL reset_cnt got %h/%h want 00/00", cnt0, cnt1); else pass_cnt++;
        total++; if ({r0, r1} !== 2'b00) $display("FAIL reset_ready got %b%b want 00", r0, r1); else pass_cnt++;
        rstn = 1'b1;
        #1;
        total++; if ({r0, r1} !== 2'b10) $display("FAIL release_ready got %b%b want 10", r0, r1); else pass_cnt++;
        step();
        total++; if ({out_valid, sel, out_data} !== {1'b1, 1'b0, 8'h3C}) $display("FAIL first_load got v%b s%b %h want v1 s0 3c", out_valid, sel, out_data); else pass_cnt++;
        total++; if (cnt0 !== 8'd1) $display("FAIL first_cnt0 got %0d want 1", cnt0); else pass_cnt++;
        v0 = 1'b0; v1 = 1'b0;
        #1;
        total++; if ({r0, r1} !== 2'b00) $display("FAIL idle_ready got %b%b want 00", r0, r1); else pass_cnt++;
        step();
        total++; if (out_valid !== 1'b0) $display("FAIL drain_valid got %b want 0", out_valid); else pass_cnt++;
    endtask

    task automatic test_stream();
        logic [7:0] words [3] = '{8'h11, 8'h22, 8'h33};
        do_reset();
        out_ready = 1'b1; v1 = 1'b1;
        for (int i = 0; i < 3; i++) begin
            d1 = words[i];
            step();
            total++; if ({out_valid, sel, out_data} !== {1'b1, 1'b1, words[i]}) $display("FAIL stream_%0d got v%b s%b %h want v1 s1 %h", i, out_valid, sel, out_data, words[i]); else pass_cnt++;
        end
        total++; if ({cnt0, cnt1} !== {8'd0, 8'd3}) $display("FAIL stream_cnt got %0d/%0d want 0/3", cnt0, cnt1); else pass_cnt++;
        v1 = 1'b0;
    endtask

    task automatic test_contention();
        logic       exp_sel;
        logic [7:0] exp_data;
        do_reset();
        out_ready = 1'b1; v0 = 1'b1; v1 = 1'b1;
        for (int i = 0; i < 4; i++) begin
            d0 = 8'hA0 + 8'(i); d1 = 8'hB0 + 8'(i);
`ifdef MUX2_STREAM_ARB_RR_EN
            exp_sel = 1'(i % 2);
`else
            exp_sel = 1'b0;
`endif
            exp_data = exp_sel ? d1 : d0;
            #1;
            total++; if ({r0, r1} !== {!exp_sel, exp_sel}) $display("FAIL cont_ready_%0d got %b%b want %b%b", i, r0, r1, !exp_sel, exp_sel); else pass_cnt++;
            step();
            total++; if ({sel, out_data} !== {exp_sel, exp_data}) $display("FAIL cont_out_%0d got s%b %h want s%b %h", i, sel, out_data, exp_sel, exp_data); else pass_cnt++;
        end
`ifdef MUX2_STREAM_ARB_RR_EN
        total++; if ({cnt0, cnt1} !== {8'd2, 8'd2}) $display("FAIL cont_cnt got %0d/%0d want 2/2", cnt0, cnt1); else pass_cnt++;
`else
        total++; if ({cnt0, cnt1} !== {8'd4, 8'd0}) $display("FAIL cont_cnt got %0d/%0d want 4/0", cnt0, cnt1); else pass_cnt++;
`endif
        v0 = 1'b0; v1 = 1'b0;
    endtask

    task automatic test_backpressure();
        do_reset();
        out_ready = 1'b1; v0 = 1'b1; d0 = 8'h5A;
        step();
        total++; if (out_data !== 8'h5A) $display("FAIL bp_load got %h want 5a", out_data); else pass_cnt++;
        out_ready = 1'b0; d0 = 8'h77;
        for (int i = 0; i < 3; i++) begin
            #1;
            total++; if (r0 !== 1'b0) $display("FAIL bp_ready_%0d got %b want 0", i, r0); else pass_cnt++;
            step();
            total++; if ({out_valid, out_data, cnt0} !== {1'b1, 8'h5A, 8'd1}) $display("FAIL bp_hold_%0d got v%b %h c%0d want v1 5a c1", i, out_valid, out_data, cnt0); else pass_cnt++;
        end
        out_ready = 1'b1;
        #1;
        total++; if (r0 !== 1'b1) $display("FAIL bp_release_ready got %b want 1", r0); else pass_cnt++;
        step();
        total++; if ({out_data, cnt0} !== {8'h77, 8'd2}) $display("FAIL bp_reload got %h c%0d want 77 c2", out_data, cnt0); else pass_cnt++;
        v0 = 1'b0;
    endtask

    task automatic test_wrap();
        do_reset();
        out_ready = 1'b1; v0 = 1'b1;
        for (int i = 0; i < 256; i++) begin
            d0 = 8'(i);
            step();
            if (i == 254) begin
                total++; if (cnt0 !== 8'd255) $display("FAIL wrap_255 got %0d want 255", cnt0); else pass_cnt++;
            end
        end
        total++; if ({cnt0, cnt1} !== 16'h0) $display("FAIL wrap_0 got %0d/%0d want 0/0", cnt0, cnt1); else pass_cnt++;
        total++; if (out_data !== 8'hFF) $display("FAIL wrap_data got %h want ff", out_data); else pass_cnt++;
        v0 = 1'b0;
    endtask

    task automatic test_mid_reset();
        do_reset();
        out_ready = 1'b1; v0 = 1'b1; d0 = 8'h99;
        step();
        out_ready = 1'b0;
        step();
        total++; if ({out_valid, cnt0} !== {1'b1, 8'd1}) $display("FAIL mid_pre got v%b c%0d want v1 c1", out_valid, cnt0); else pass_cnt++;
        #3 rstn = 1'b0;
        #1;
        total++; if ({out_valid, out_data, cnt0, r0} !== {1'b0, 8'h00, 8'd0, 1'b0}) $display("FAIL mid_async got v%b %h c%0d r%b want v0 00 c0 r0", out_valid, out_data, cnt0, r0); else pass_cnt++;
        #1 rstn = 1'b1;
        out_ready = 1'b1; d0 = 8'h42;
        step();
        total++; if ({out_valid, sel, out_data, cnt0} !== {1'b1, 1'b0, 8'h42, 8'd1}) $display("FAIL mid_after got v%b s%b %h c%0d want v1 s0 42 c1", out_valid, sel, out_data, cnt0); else pass_cnt++;
        v0 = 1'b0;
    endtask

    initial begin
        test_reset();
        test_stream();
        test_contention();
        test_backpressure();
        test_wrap();
        test_mid_reset();
        $display("%0d/%0d checks passed", pass_cnt, total);
        $finish;
    end
endmodule

// File: doc/mux2_stream_arb.md
# mux2_stream_arb

Registered two-input stream arbiter that sits directly upstream of the 2:1 mux stage and makes its selection sequential. Two valid/ready producer channels compete for one output channel; the block drives the select internally, captures the winning word into a single-entry output register, and reports which input won. Per-input transfer counters support bench checking and debug.

## Interface
- DW, default 8: data width of both inputs and the output.
- CNT_W, default 8: width of each per-input transfer counter.

- i_clk  input  1  rising-edge clock.
- i_rstn  input  1  asynchronous active-low reset.
- i_in0_data  input  DW  channel 0 data.
- i_in0_valid  input  1  channel 0 word available.
- o_in0_ready  output  1  channel 0 word accepted this cycle when high with i_in0_valid.
- i_in1_data  input  DW  channel 1 data.
- i_in1_valid  input  1  channel 1 word available.
- o_in1_ready  output  1  channel 1 word accepted this cycle when high with i_in1_valid.
- o_out_data  output  DW  registered output word.
- o_out_valid  output  1  output register holds a word.
- i_out_ready  input  1  consumer accepts the output word this cycle.
- o_sel  output  1  source of the word in o_out_data: 0 = in0, 1 = in1.
- o_cnt0  output  CNT_W  accepted channel-0 transfers.
- o_cnt1  output  CNT_W  accepted channel-1 transfers.

## Operation
- load = !o_out_valid || i_out_ready: the output register can take a new word this cycle.
- Grant is combinational from the valids: only in0 valid -> 0; only in1 valid -> 1; both valid -> priority rule under Configuration; none valid -> no grant.
- o_inX_ready = i_rstn && load && (grant == X). At most one ready is high; ready never depends on the requester's own data.
- Transfer on channel X: i_inX_valid && o_inX_ready. On that edge: o_out_data <= i_inX_data, o_sel <= X, o_cntX <= o_cntX + 1.
- o_out_valid next: if load, then (i_in0_valid || i_in1_valid); otherwise it holds 1.
- While o_out_valid && !i_out_ready, o_out_data, o_sel and o_out_valid hold. Both readies are 0.
- The output is consumed and refilled in the same cycle (i_out_ready=1 plus a transfer), so full throughput is one word per cycle.
- Counters wrap modulo 2^CNT_W (255 -> 0 at CNT_W=8). They do not saturate.
- Internal state last_sel records the most recent granted channel and updates only on a transfer.

## Timing
- Input-to-output latency: 1 cycle. A word accepted at edge N is visible on o_out_data/o_out_valid after edge N.
- Reset (i_rstn low, asynchronous): o_out_data=0, o_out_valid=0, o_sel=0, o_cnt0=0, o_cnt1=0, last_sel=1, o_in0_ready=0, o_in1_ready=0.
- Reset mid-transfer: the held output word is discarded and no counter increments. After release, the first edge with a valid input loads normally.
- Valids may drop without a transfer. The grant is re-evaluated every cycle, with no lock between cycles.

## Configuration
- Macro MUX2_STREAM_ARB_RR_EN.
- Defined: round-robin. On contention, the grant goes to !last_sel. With last_sel=1 after reset, in0 wins the first contention, then the channels alternate.
- Undefined: fixed priority. On contention, in0 always wins. last_sel is still maintained but does not affect the grant.

## Test plan
- Reset check: assert i_rstn=0 for 3 cycles with both valids high -> all outputs 0 and both readies 0. Release -> the first edge loads in0 data and o_sel=0.
- Single channel streaming: in1 only, data 0x11,0x22,0x33, i_out_ready=1 -> output shows 0x11,0x22,0x33 on consecutive cycles, o_sel=1, o_cnt1=3, o_cnt0=0.
- Contention with RR_EN defined: both valid for 4 cycles, in0 data=0xA0.., in1 data=0xB0.., i_out_ready=1 -> o_sel sequence 0,1,0,1 and o_cnt0=o_cnt1=2. With RR_EN undefined: o_sel stays 0 and o_cnt0=4.
- Backpressure: output holds 0x5A, then i_out_ready=0 for 3 cycles with in0 valid -> o_out_data stays 0x5A, o_in0_ready=0, no count change. i_out_ready=1 -> the new word loads on the next edge.
- Counter wrap: 256 in0 transfers with CNT_W=8 -> o_cnt0 returns to 0.
- Mid-operation reset: o_out_valid=1 and i_out_ready=0 when i_rstn pulses low mid-cycle -> o_out_valid drops immediately with no clock edge, and counters are 0.
